// File: rtl/max_pool_stream.sv
// -----------------------------------------------------------------------------
// max_pool_stream
//
// Streaming max-pooling block. Samples arrive on a valid/ready input. Every
// POOL_N accepted samples form one group. The block reports the largest
// sample of each group and the position of that sample within the group. On
// ties the earliest position wins. The result is held on a valid/ready output
// until the downstream consumes it.
//
// The block takes one sample per cycle. While a result is pending it still
// accepts the first POOL_N-1 samples of the next group. It stalls only when
// the group-completing sample would overwrite a result that nobody has
// consumed yet.
//
// Parameters
//   DATA_W  sample width in bits (2..32)
//   POOL_N  samples per pooling group (2..256)
//   SIGNED  0 = unsigned compare, 1 = two's complement compare
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   clear      synchronous abort of the partial group; blocks acceptance
//   in_valid   in_data carries a sample this cycle
//   in_data    sample
//   in_ready   block accepts in_data this cycle
//   out_valid  out_data/out_idx hold a completed group result
//   out_data   maximum of the group
//   out_idx    position of the maximum within the group
//   out_ready  downstream consumes the result this cycle
//   grp_cnt    samples accepted so far in the current partial group
// -----------------------------------------------------------------------------
module max_pool_stream #(
    parameter int DATA_W = 8,
    parameter int POOL_N = 4,
    parameter int SIGNED = 0,
    localparam int IDX_W = ($clog2(POOL_N) > 1) ? $clog2(POOL_N) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  grp_cnt
);

    // Position of the group-completing sample.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POOL_N - 1);

    // Running state of the partial group.
    logic [IDX_W-1:0]  grpCnt_q,  grpCnt_d;
    logic [DATA_W-1:0] runMax_q,  runMax_d;
    logic [IDX_W-1:0]  runIdx_q,  runIdx_d;

    // Registered result presented downstream.
    logic              outValid_q, outValid_d;
    logic [DATA_W-1:0] outData_q,  outData_d;
    logic [IDX_W-1:0]  outIdx_q,   outIdx_d;

    // Handshake and datapath helpers.
    logic              inReady;
    logic              acceptEn;
    logic              consumeEn;
    logic              lastAccept;
    logic              isGreater;
    logic [DATA_W-1:0] candMax;
    logic [IDX_W-1:0]  candIdx;

    // Ready depends only on registered state and out_ready, never on
    // in_valid. The only stall is when the group-completing sample would
    // overwrite a result that is not being consumed this cycle.
    always_comb begin
        inReady   = !((grpCnt_q == LAST_IDX) && outValid_q && !out_ready);
        acceptEn  = in_valid && inReady && !clear;
        consumeEn = outValid_q && out_ready;
        lastAccept = acceptEn && (grpCnt_q == LAST_IDX);
    end

    // Strict greater-than keeps the earliest index on ties. The compare mode
    // is fixed by the parameter. in_data itself is never altered.
    always_comb begin
        if (SIGNED != 0) begin
            isGreater = $signed(in_data) > $signed(runMax_q);
        end else begin
            isGreater = in_data > runMax_q;
        end
    end

    // Candidate max/index after folding in the current sample. The first
    // sample of a group loads unconditionally, whatever the stale register
    // holds.
    always_comb begin
        candMax = runMax_q;
        candIdx = runIdx_q;
        if ((grpCnt_q == '0) || isGreater) begin
            candMax = in_data;
            candIdx = grpCnt_q;
        end
    end

    // Next-state logic for the running group and the output register.
    // clear wins over acceptance and leaves the pending result untouched.
    // A completing sample and a consume in the same cycle hand over
    // seamlessly: the new result replaces the old one and valid stays high.
    always_comb begin
        grpCnt_d   = grpCnt_q;
        runMax_d   = runMax_q;
        runIdx_d   = runIdx_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outIdx_d   = outIdx_q;

        if (clear) begin
            grpCnt_d = '0;
            runMax_d = '0;
            runIdx_d = '0;
        end else if (acceptEn) begin
            if (lastAccept) begin
                grpCnt_d  = '0;
                runMax_d  = '0;
                runIdx_d  = '0;
                outData_d = candMax;
                outIdx_d  = candIdx;
            end else begin
                grpCnt_d = grpCnt_q + 1'b1;
                runMax_d = candMax;
                runIdx_d = candIdx;
            end
        end

        if (lastAccept) begin
            outValid_d = 1'b1;
        end else if (consumeEn) begin
            outValid_d = 1'b0;
        end
    end

    // State registers. Reset drops any partial group and any pending result
    // immediately, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grpCnt_q   <= '0;
            runMax_q   <= '0;
            runIdx_q   <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outIdx_q   <= '0;
        end else begin
            grpCnt_q   <= grpCnt_d;
            runMax_q   <= runMax_d;
            runIdx_q   <= runIdx_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outIdx_q   <= outIdx_d;
        end
    end

    assign in_ready  = inReady;
    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_idx   = outIdx_q;
    assign grp_cnt   = grpCnt_q;

endmodule
